// File: rtl/alu_writeback_if.sv
// alu_writeback_if: ALU result handshake, SREG feedback, register-file write port and hazard query
interface alu_writeback_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_result;
   logic [ADDR_WIDTH-1:0] in_rd_addr;
   logic                  in_wr_reg;
   logic [DATA_WIDTH-1:0] in_flags;
   logic [DATA_WIDTH-1:0] in_flags_mask;
   logic [DATA_WIDTH-1:0] sreg;
   logic                  rf_we;
   logic [ADDR_WIDTH-1:0] rf_addr;
   logic [DATA_WIDTH-1:0] rf_data;
   logic                  rf_ready;
   logic [ADDR_WIDTH-1:0] q_addr;
   logic                  q_hit;
   logic                  busy;

   modport master (
      output flush, in_valid, in_result, in_rd_addr, in_wr_reg, in_flags, in_flags_mask, rf_ready, q_addr,
      input  in_ready, sreg, rf_we, rf_addr, rf_data, q_hit, busy
   );

   modport slave (
      input  flush, in_valid, in_result, in_rd_addr, in_wr_reg, in_flags, in_flags_mask, rf_ready, q_addr,
      output in_ready, sreg, rf_we, rf_addr, rf_data, q_hit, busy
   );
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback: owns SREG, queues ALU results in order and drains them to the register file
module alu_writeback #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 2
) (
   input logic         clk,
   input logic         rst_n,
   alu_writeback_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DEPTH-1:0]      wr_q;
   logic [DEPTH-1:0]      vld_q;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] sreg_q;
   logic                  head_valid;
   logic                  push;
   logic                  pop;
   logic                  hit;

   assign head_valid   = count != '0;
   assign bus.in_ready = (count < CW'(DEPTH)) && !bus.flush;
   assign push         = bus.in_valid && bus.in_ready;
   assign bus.rf_we    = head_valid && wr_q[rd_ptr];
   assign pop          = head_valid && (!wr_q[rd_ptr] || bus.rf_ready);
   assign bus.rf_addr  = head_valid ? addr_q[rd_ptr] : '0;
   assign bus.rf_data  = head_valid ? data_q[rd_ptr] : '0;
   assign bus.busy     = head_valid;
   assign bus.sreg     = sreg_q;
   assign bus.q_hit    = hit;

   // hazard: any queued register write targeting the queried address
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         hit = hit | (vld_q[i] & wr_q[i] & (addr_q[i] == bus.q_addr));
   end

   // entry payload storage, written on push
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr] <= bus.in_result;
         addr_q[wr_ptr] <= bus.in_rd_addr;
      end
   end

   // SREG, pointers, occupancy and entry flags; flush drops the queue but keeps SREG
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         vld_q  <= '0;
         wr_q   <= '0;
      end else if (bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         vld_q  <= '0;
      end else begin
         if (push) begin
            sreg_q       <= (sreg_q & ~bus.in_flags_mask) | (bus.in_flags & bus.in_flags_mask);
            wr_q[wr_ptr] <= bus.in_wr_reg;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_ptr == PW'(i)) vld_q[i] <= 1'b1;
            else if (pop && rd_ptr == PW'(i)) vld_q[i] <= 1'b0;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed scenario tests for the ALU writeback stage
module tb_alu_writeback;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;

   alu_writeback_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

   alu_writeback #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.flush = 0; bus.in_valid = 0; bus.in_result = 0; bus.in_rd_addr = 0;
      bus.in_wr_reg = 0; bus.in_flags = 0; bus.in_flags_mask = 0; bus.rf_ready = 0; bus.q_addr = 0;
   endtask

   task automatic drive(input logic [7:0] res, input logic [4:0] rd, input logic wr,
                        input logic [7:0] fl, input logic [7:0] mk);
      bus.in_valid = 1; bus.in_result = res; bus.in_rd_addr = rd;
      bus.in_wr_reg = wr; bus.in_flags = fl; bus.in_flags_mask = mk;
   endtask

   task automatic test_reset;
      idle();
      rst_n = 0;
      tick(); tick();
      checks++; if (bus.sreg !== 8'h00) begin failures++; $display("FAIL reset_sreg got=%h exp=00", bus.sreg); end
      checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", bus.rf_we); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.q_hit !== 1'b0) begin failures++; $display("FAIL reset_q_hit got=%b exp=0", bus.q_hit); end
      rst_n = 1;
      tick();
   endtask

   task automatic test_single_write;
      bus.rf_ready = 1;
      drive(8'h5A, 5'd3, 1'b1, 8'h03, 8'h3F);
      tick();
      bus.in_valid = 0;
      #1;
      checks++; if (bus.sreg !== 8'h03) begin failures++; $display("FAIL single_sreg got=%h exp=03", bus.sreg); end
      checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("FAIL single_rf_we got=%b exp=1", bus.rf_we); end
      checks++; if (bus.rf_addr !== 5'd3) begin failures++; $display("FAIL single_rf_addr got=%0d exp=3", bus.rf_addr); end
      checks++; if (bus.rf_data !== 8'h5A) begin failures++; $display("FAIL single_rf_data got=%h exp=5a", bus.rf_data); end
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", bus.busy); end
      checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL single_rf_we_after got=%b exp=0", bus.rf_we); end
   endtask

   task automatic test_backpressure;
      bus.rf_ready = 0;
      drive(8'h11, 5'd1, 1'b1, 8'h00, 8'h00);
      tick();
      drive(8'h22, 5'd2, 1'b1, 8'h00, 8'h00);
      tick();
      drive(8'h33, 5'd3, 1'b1, 8'hFF, 8'hFF);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%b exp=0", bus.in_ready); end
      checks++; if (bus.rf_addr !== 5'd1) begin failures++; $display("FAIL bp_hold_addr got=%0d exp=1", bus.rf_addr); end
      tick();
      checks++; if (bus.rf_addr !== 5'd1 || bus.rf_data !== 8'h11 || bus.rf_we !== 1'b1) begin failures++; $display("FAIL bp_hold2 got=%b/%0d/%h exp=1/1/11", bus.rf_we, bus.rf_addr, bus.rf_data); end
      checks++; if (bus.sreg !== 8'h03) begin failures++; $display("FAIL bp_no_accept_sreg got=%h exp=03", bus.sreg); end
      bus.in_valid = 0;
      bus.rf_ready = 1;
      tick();
      checks++; if (bus.rf_addr !== 5'd2 || bus.rf_data !== 8'h22) begin failures++; $display("FAIL bp_drain2 got=%0d/%h exp=2/22", bus.rf_addr, bus.rf_data); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", bus.in_ready); end
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL bp_drained_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_back_to_back;
      bus.rf_ready = 1;
      drive(8'h40, 5'd4, 1'b1, 8'h00, 8'h00);
      tick();
      drive(8'h50, 5'd5, 1'b1, 8'h00, 8'h00);
      #1;
      checks++; if (bus.rf_addr !== 5'd4 || bus.rf_data !== 8'h40) begin failures++; $display("FAIL b2b_first got=%0d/%h exp=4/40", bus.rf_addr, bus.rf_data); end
      tick();
      drive(8'h60, 5'd6, 1'b1, 8'h00, 8'h00);
      #1;
      checks++; if (bus.rf_addr !== 5'd5 || bus.rf_data !== 8'h50) begin failures++; $display("FAIL b2b_second got=%0d/%h exp=5/50", bus.rf_addr, bus.rf_data); end
      tick();
      bus.in_valid = 0;
      #1;
      checks++; if (bus.rf_addr !== 5'd6 || bus.rf_data !== 8'h60 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_third got=%0d/%h/%b exp=6/60/1", bus.rf_addr, bus.rf_data, bus.in_ready); end
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_flag_mask;
      bus.rf_ready = 0;
      drive(8'h00, 5'd0, 1'b0, 8'hFF, 8'hFF);
      tick();
      checks++; if (bus.sreg !== 8'hFF) begin failures++; $display("FAIL flag_set_all got=%h exp=ff", bus.sreg); end
      drive(8'h00, 5'd0, 1'b0, 8'h00, 8'h0F);
      #1;
      checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL flag_rf_we1 got=%b exp=0", bus.rf_we); end
      tick();
      checks++; if (bus.sreg !== 8'hF0) begin failures++; $display("FAIL flag_masked got=%h exp=f0", bus.sreg); end
      checks++; if (bus.rf_we !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL flag_rf_we2 got=%b/%b exp=0/1", bus.rf_we, bus.busy); end
      drive(8'h00, 5'd0, 1'b0, 8'hAA, 8'h00);
      tick();
      bus.in_valid = 0;
      checks++; if (bus.sreg !== 8'hF0) begin failures++; $display("FAIL flag_mask0 got=%h exp=f0", bus.sreg); end
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flag_retire got=%b exp=0", bus.busy); end
   endtask

   task automatic test_hazard_flush;
      bus.rf_ready = 0;
      drive(8'h77, 5'd7, 1'b1, 8'h00, 8'h00);
      tick();
      bus.in_valid = 0;
      bus.q_addr = 5'd7;
      #1;
      checks++; if (bus.q_hit !== 1'b1) begin failures++; $display("FAIL haz_hit got=%b exp=1", bus.q_hit); end
      bus.q_addr = 5'd8;
      #1;
      checks++; if (bus.q_hit !== 1'b0) begin failures++; $display("FAIL haz_miss got=%b exp=0", bus.q_hit); end
      bus.q_addr = 5'd7;
      bus.flush = 1;
      drive(8'h88, 5'd8, 1'b1, 8'hFF, 8'hFF);
      #1;
      checks++; if (bus.in_ready !== 1'b0 || bus.rf_we !== 1'b1) begin failures++; $display("FAIL flush_cycle got=%b/%b exp=0/1", bus.in_ready, bus.rf_we); end
      tick();
      bus.flush = 0;
      bus.in_valid = 0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.q_hit !== 1'b0) begin failures++; $display("FAIL flush_clear got=%b/%b exp=0/0", bus.busy, bus.q_hit); end
      checks++; if (bus.sreg !== 8'hF0) begin failures++; $display("FAIL flush_sreg got=%h exp=f0", bus.sreg); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_async_reset;
      bus.rf_ready = 0;
      drive(8'h99, 5'd9, 1'b1, 8'h55, 8'hFF);
      tick();
      bus.in_valid = 0;
      checks++; if (bus.rf_we !== 1'b1 || bus.sreg !== 8'h55) begin failures++; $display("FAIL arst_pre got=%b/%h exp=1/55", bus.rf_we, bus.sreg); end
      #2;
      rst_n = 0;
      #1;
      checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL arst_rf_we got=%b exp=0", bus.rf_we); end
      checks++; if (bus.sreg !== 8'h00) begin failures++; $display("FAIL arst_sreg got=%h exp=00", bus.sreg); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
      tick();
      #2;
      rst_n = 1;
      tick();
      checks++; if (bus.in_ready !== 1'b1 || bus.rf_we !== 1'b0) begin failures++; $display("FAIL arst_after got=%b/%b exp=1/0", bus.in_ready, bus.rf_we); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_backpressure();
      test_back_to_back();
      test_flag_mask();
      test_hazard_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
